// File: rtl/mips_seq_pkg.sv
// mips_seq_pkg: phase codes, opcodes and controller states shared by the sequencer and control unit
package mips_seq_pkg;
  localparam logic [3:0] IDLE_CODE  = 4'hF;
  localparam logic [2:0] PH_FETCH   = 3'd0;
  localparam logic [2:0] PH_DECODE  = 3'd1;
  localparam logic [2:0] PH_EXEC    = 3'd2;
  localparam logic [2:0] PH_MEM     = 3'd3;
  localparam logic [2:0] PH_WB_LOAD = 3'd4;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  typedef enum logic [1:0] {IDLE, EXEC, HALT} seq_state_e;
endpackage

// File: rtl/opcode_phase_lut.sv
// opcode_phase_lut: maps an opcode to its legality and the index of its final phase
module opcode_phase_lut
  import mips_seq_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       legal,
  output logic [2:0] last_phase
);
  always_comb begin
    legal = 1'b1;
    last_phase = PH_MEM;
    case (opcode)
      OP_RTYPE, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: last_phase = PH_MEM;
      OP_LW: last_phase = PH_WB_LOAD;
      OP_BEQ, OP_BNE, OP_J, OP_JAL: last_phase = PH_EXEC;
      default: begin
        legal = 1'b0;
        last_phase = PH_FETCH;
      end
    endcase
  end
endmodule

// File: rtl/mips_state_sequencer.sv
// mips_state_sequencer: issues per-instruction phase codes to the multicycle core,
// with run/step/halt control and cycle/retired-instruction counters
module mips_state_sequencer #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [3:0] IDLE_CODE  = mips_seq_pkg::IDLE_CODE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  step,
  input  logic [5:0]            opcode,
  output logic [3:0]            count_state,
  output logic                  instr_done,
  output logic                  halted,
  output logic [5:0]            illegal_op,
  output logic [DATA_WIDTH-1:0] cycle_count,
  output logic [DATA_WIDTH-1:0] instr_count
);
  import mips_seq_pkg::*;
  seq_state_e            state_q;
  logic [2:0]            ph_q, last_ph_q;
  logic                  single_q, halted_q;
  logic [5:0]            illegal_op_q;
  logic [DATA_WIDTH-1:0] cycle_q, instr_q;
  logic                  legal;
  logic [2:0]            last_phase;
  logic                  is_last;
  opcode_phase_lut u_lut (
    .opcode    (opcode),
    .legal     (legal),
    .last_phase(last_phase)
  );
  // phases from execute onward only ever compare against the latched length
  assign is_last     = state_q == EXEC && ph_q >= PH_EXEC && ph_q == last_ph_q;
  assign count_state = state_q == EXEC ? {1'b0, ph_q} : IDLE_CODE;
  assign instr_done  = is_last;
  assign halted      = halted_q;
  assign illegal_op  = illegal_op_q;
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ph_q         <= PH_FETCH;
      last_ph_q    <= PH_FETCH;
      single_q     <= 1'b0;
      halted_q     <= 1'b0;
      illegal_op_q <= '0;
      cycle_q      <= '0;
      instr_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (run || step) begin
          state_q  <= EXEC;
          ph_q     <= PH_FETCH;
          single_q <= !run;
        end
        EXEC: begin
          cycle_q <= cycle_q + DATA_WIDTH'(1);
          if (ph_q == PH_DECODE) begin
            if (!legal) begin
              state_q      <= HALT;
              halted_q     <= 1'b1;
              illegal_op_q <= opcode;
            end else begin
              last_ph_q <= last_phase;
              ph_q      <= PH_EXEC;
            end
          end else if (is_last) begin
            instr_q <= instr_q + DATA_WIDTH'(1);
            if (single_q || !run) begin
              state_q  <= IDLE;
              single_q <= 1'b0;
            end else ph_q <= PH_FETCH;
          end else ph_q <= ph_q + 3'd1;
        end
        default: ;
      endcase
    end
  end
endmodule
